// File: rtl/ace_snoop_responder_if.sv
// Bus bundle between the CCU snoop port / dcache lookup port and ace_snoop_responder.
// The responder uses the slave view; the CCU+cache side (or a bench) uses the master view.
interface ace_snoop_responder_if #(
  parameter int unsigned AddrWidth       = 64,
  parameter int unsigned DataWidth       = 64,
  parameter int unsigned DcacheLineWidth = 128
);
  logic                       ac_valid_i;
  logic                       ac_ready_o;
  logic [AddrWidth-1:0]       ac_addr_i;
  logic [3:0]                 ac_snoop_i;
  logic                       cr_valid_o;
  logic                       cr_ready_i;
  logic [4:0]                 cr_resp_o;
  logic                       cd_valid_o;
  logic                       cd_ready_i;
  logic [DataWidth-1:0]       cd_data_o;
  logic                       cd_last_o;
  logic                       lu_req_o;
  logic                       lu_gnt_i;
  logic [AddrWidth-1:0]       lu_addr_o;
  logic                       lu_share_o;
  logic                       lu_clean_o;
  logic                       lu_inval_o;
  logic                       lu_valid_i;
  logic                       lu_hit_i;
  logic                       lu_dirty_i;
  logic                       lu_shared_i;
  logic [DcacheLineWidth-1:0] lu_data_i;

  modport slave (
    input  ac_valid_i, ac_addr_i, ac_snoop_i, cr_ready_i, cd_ready_i,
           lu_gnt_i, lu_valid_i, lu_hit_i, lu_dirty_i, lu_shared_i, lu_data_i,
    output ac_ready_o, cr_valid_o, cr_resp_o, cd_valid_o, cd_data_o, cd_last_o,
           lu_req_o, lu_addr_o, lu_share_o, lu_clean_o, lu_inval_o
  );

  modport master (
    output ac_valid_i, ac_addr_i, ac_snoop_i, cr_ready_i, cd_ready_i,
           lu_gnt_i, lu_valid_i, lu_hit_i, lu_dirty_i, lu_shared_i, lu_data_i,
    input  ac_ready_o, cr_valid_o, cr_resp_o, cd_valid_o, cd_data_o, cd_last_o,
           lu_req_o, lu_addr_o, lu_share_o, lu_clean_o, lu_inval_o
  );
endinterface

// File: rtl/ace_snoop_responder.sv
// ACE snoop responder: takes one AC snoop at a time, does one atomic dcache lookup/update,
// answers on CR and streams the line on CD when the response carries data.
module ace_snoop_responder #(
  parameter int unsigned AddrWidth       = 64,
  parameter int unsigned DataWidth       = 64,
  parameter int unsigned DcacheLineWidth = 128
) (
  input logic                  clk_i,
  input logic                  rst_ni,
  ace_snoop_responder_if.slave bus
);
  localparam int unsigned Beats   = DcacheLineWidth / DataWidth;
  localparam int unsigned LineOff = $clog2(DcacheLineWidth / 8);
  localparam int unsigned BeatW   = (Beats > 1) ? $clog2(Beats) : 1;
  localparam logic [BeatW-1:0] LastBeat = BeatW'(Beats - 1);

  localparam logic [3:0] ReadOnce     = 4'b0000;
  localparam logic [3:0] ReadShared   = 4'b0001;
  localparam logic [3:0] ReadClean    = 4'b0010;
  localparam logic [3:0] ReadNsd      = 4'b0011;
  localparam logic [3:0] ReadUnique   = 4'b0111;
  localparam logic [3:0] CleanShared  = 4'b1000;
  localparam logic [3:0] CleanInvalid = 4'b1001;
  localparam logic [3:0] MakeInvalid  = 4'b1101;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOOKUP = 3'd1,
    S_WAIT   = 3'd2,
    S_RESP   = 3'd3,
    S_DATA   = 3'd4
  } state_e;

  state_e                             r_state;
  state_e                             w_next_state;
  logic [AddrWidth-1:0]               r_addr;
  logic [3:0]                         r_snoop;
  logic [4:0]                         r_resp;
  logic [Beats-1:0][DataWidth-1:0]    r_line;
  logic [BeatW-1:0]                   r_beat;

  // {share, clean, inval} applied by the cache only when the line hits
  function automatic logic [2:0] lookup_op(input logic [3:0] snoop);
    logic [2:0] op;
    case (snoop)
      ReadShared, ReadNsd:                    op = 3'b110;
      ReadClean:                              op = 3'b100;
      ReadUnique, CleanInvalid, MakeInvalid:  op = 3'b001;
      CleanShared:                            op = 3'b010;
      default:                                op = 3'b000;
    endcase
    return op;
  endfunction

  // {WasUnique, IsShared, PassDirty, Error, DataTransfer} from the pre-update line state
  function automatic logic [4:0] snoop_resp(input logic [3:0] snoop, input logic hit,
                                            input logic dirty, input logic shared);
    logic [2:0] is_pd_dt;
    logic       known;
    known = 1'b1;
    case (snoop)
      ReadOnce, ReadClean: is_pd_dt = 3'b101;
      ReadShared, ReadNsd: is_pd_dt = {1'b1, dirty, 1'b1};
      ReadUnique:          is_pd_dt = {1'b0, dirty, 1'b1};
      CleanInvalid:        is_pd_dt = {1'b0, dirty, dirty};
      CleanShared:         is_pd_dt = {1'b1, dirty, dirty};
      MakeInvalid:         is_pd_dt = 3'b000;
      default: begin
        is_pd_dt = 3'b000;
        known    = 1'b0;
      end
    endcase
    if (hit && known) begin
      return {!shared, is_pd_dt[2], is_pd_dt[1], 1'b0, is_pd_dt[0]};
    end else begin
      return 5'b00000;
    end
  endfunction

  // State register
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:   if (bus.ac_valid_i) w_next_state = S_LOOKUP; else w_next_state = S_IDLE;
      S_LOOKUP: if (bus.lu_gnt_i)   w_next_state = S_WAIT;   else w_next_state = S_LOOKUP;
      S_WAIT:   if (bus.lu_valid_i) w_next_state = S_RESP;   else w_next_state = S_WAIT;
      S_RESP: begin
        if (bus.cr_ready_i) begin
          w_next_state = r_resp[0] ? S_DATA : S_IDLE;
        end else begin
          w_next_state = S_RESP;
        end
      end
      S_DATA: begin
        if (bus.cd_ready_i && (r_beat == LastBeat)) begin
          w_next_state = S_IDLE;
        end else begin
          w_next_state = S_DATA;
        end
      end
      default:  w_next_state = S_IDLE;
    endcase
  end

  // Request latch, lookup result capture and beat counter
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_addr  <= '0;
      r_snoop <= 4'b0000;
      r_resp  <= 5'b00000;
      r_line  <= '0;
      r_beat  <= '0;
    end else begin
      if ((r_state == S_IDLE) && bus.ac_valid_i) begin
        r_addr  <= bus.ac_addr_i;
        r_snoop <= bus.ac_snoop_i;
      end
      if ((r_state == S_WAIT) && bus.lu_valid_i) begin
        r_resp <= snoop_resp(r_snoop, bus.lu_hit_i, bus.lu_dirty_i, bus.lu_shared_i);
        r_line <= bus.lu_data_i;
      end
      if ((r_state == S_DATA) && bus.cd_ready_i) begin
        r_beat <= (r_beat == LastBeat) ? '0 : r_beat + BeatW'(1);
      end
    end
  end

  // Outputs decoded from registered state only, so they are stable across stalls
  always_comb begin
    bus.ac_ready_o = rst_ni && (r_state == S_IDLE);
    bus.lu_req_o   = (r_state == S_LOOKUP);
    bus.lu_addr_o  = {r_addr[AddrWidth-1:LineOff], {LineOff{1'b0}}};
    if (r_state == S_LOOKUP) begin
      {bus.lu_share_o, bus.lu_clean_o, bus.lu_inval_o} = lookup_op(r_snoop);
    end else begin
      {bus.lu_share_o, bus.lu_clean_o, bus.lu_inval_o} = 3'b000;
    end
    bus.cr_valid_o = (r_state == S_RESP);
    bus.cr_resp_o  = (r_state == S_RESP) ? r_resp : 5'b00000;
    bus.cd_valid_o = (r_state == S_DATA);
    if (r_state == S_DATA) begin
      bus.cd_data_o = r_line[r_beat];
      bus.cd_last_o = (r_beat == LastBeat);
    end else begin
      bus.cd_data_o = '0;
      bus.cd_last_o = 1'b0;
    end
  end
endmodule
